// File: rtl/cordic_vec_rtl.sv
// Vectoring-mode CORDIC: converts a right-half-plane Cartesian vector (x, y)
// into its angle atan2(y, x) and its magnitude, using one shift-add datapath
// reused over i_max iterations. Angle and magnitude share the I/O fixed-point
// format (1.0 = 2**(W-2)), so angle_out can drive a rotation-mode block directly.
module cordic_vec_rtl #(
  parameter int W          = 12,  // I/O width, signed, 1.0 = 2**(W-2)
  parameter int i_max      = 10,  // iteration count, 2..14
  parameter int guard_bits = 0    // extra LSBs carried internally
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  output logic                ready_out,
  output logic signed [W-1:0] angle_out,
  output logic        [W-1:0] mag_out,
  output logic                err_out
);

  localparam int W1 = W + guard_bits;  // angle accumulator width
  localparam int W2 = W1 + 2;          // x/y width, headroom for the 1.647 gain
  localparam int ZF = W1 - 2;          // fraction bits of the internal format
  localparam int IW = 4;               // iteration counter width (i_max <= 14)

  // Tables are held at 16 fraction bits and rescaled to ZF bits with rounding.
  localparam int SH_R = (ZF < 16) ? 16 - ZF : 0;
  localparam int SH_L = (ZF > 16) ? ZF - 16 : 0;
  localparam int RND  = (SH_R > 0) ? (1 << (SH_R - 1)) : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEL, S_UPD, S_SCALE, S_OUT, S_WAIT
  } state_t;

  // atan(2**-i) in radians, 16 fraction bits.
  function automatic int atan_q16(input int idx);
    case (idx)
      0:       return 51472;
      1:       return 30386;
      2:       return 16055;
      3:       return 8150;
      4:       return 4091;
      5:       return 2047;
      6:       return 1024;
      7:       return 512;
      8:       return 256;
      9:       return 128;
      10:      return 64;
      11:      return 32;
      12:      return 16;
      13:      return 8;
      14:      return 4;
      default: return 0;
    endcase
  endfunction

  // Inverse CORDIC gain after n iterations, prod 1/sqrt(1+2**-2i), 16 fraction bits.
  function automatic int kn_q16(input int n);
    case (n)
      1:       return 46341;
      2:       return 41449;
      3:       return 40211;
      4:       return 39901;
      5:       return 39823;
      6:       return 39803;
      7:       return 39799;
      default: return 39797;
    endcase
  endfunction

  function automatic logic signed [W1-1:0] q16_to_fix(input int v);
    return W1'(((v + RND) >>> SH_R) <<< SH_L);
  endfunction

  localparam logic signed [W1-1:0] KN      = q16_to_fix(kn_q16(i_max));
  localparam logic signed [W2-1:0] MAG_MAX = W2'((2 ** (W - 1)) - 1);

  state_t                    r_state;
  state_t                    w_next;
  logic signed [W2-1:0]      r_x, r_y, r_xs, r_ys, r_m;
  logic signed [W1-1:0]      r_z, r_at;
  logic                      r_dir;
  logic        [IW-1:0]      r_i;
  logic                      r_ready, r_err;
  logic signed [W-1:0]       r_angle;
  logic        [W-1:0]       r_mag;

  logic                      w_neg, w_forced, w_last;
  logic signed [W1-1:0]      w_atan;
  logic signed [W2+W1-1:0]   w_p;
  logic signed [W2-1:0]      w_m_sh;
  logic        [W-1:0]       w_mag_sat;

  // NOTE: the angle table is a constant function of r_i and folds into a small
  // ROM; constant tables carry no state, so they need no reset.
  assign w_atan   = q16_to_fix(atan_q16(int'(r_i)));
  assign w_neg    = x_in[W-1];
  assign w_forced = w_neg || ((x_in == '0) && (y_in == '0));
  assign w_last   = (int'(r_i) + 1) >= i_max;
  assign w_p      = (W2+W1)'(r_x) * (W2+W1)'(KN);
  assign w_m_sh   = r_m >>> guard_bits;

  // Saturate the scaled magnitude into the unsigned-valued output range.
  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_mag_sat = W'(w_m_sh);
    if (w_m_sh[W2-1])          w_mag_sat = '0;
    else if (w_m_sh > MAG_MAX) w_mag_sat = W'(MAG_MAX);
  end

  // State register; reset aborts any computation in flight.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic for the handshake and the iteration loop.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = w_forced ? S_OUT : S_SEL;
      S_SEL:   w_next = S_UPD;
      S_UPD:   w_next = w_last ? S_SCALE : S_SEL;
      S_SCALE: w_next = S_OUT;
      S_OUT:   w_next = S_WAIT;
      S_WAIT:  if (!start) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: load, micro-rotate toward y=0 accumulating the angle, scale, publish.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_xs    <= '0;
      r_ys    <= '0;
      r_m     <= '0;
      r_z     <= '0;
      r_at    <= '0;
      r_dir   <= 1'b0;
      r_i     <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_angle <= '0;
      r_mag   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          // Left-half-plane and zero vectors keep z = m = 0 and go straight to OUT.
          r_x     <= W2'(x_in) <<< guard_bits;
          r_y     <= W2'(y_in) <<< guard_bits;
          r_z     <= '0;
          r_m     <= '0;
          r_i     <= '0;
          r_ready <= 1'b0;
          r_err   <= w_neg;
        end
        S_SEL: begin
          r_xs  <= r_x >>> r_i;
          r_ys  <= r_y >>> r_i;
          r_at  <= w_atan;
          r_dir <= ~r_y[W2-1];  // y == 0 rotates clockwise, like y > 0
        end
        S_UPD: begin
          if (r_dir) begin
            r_x <= r_x + r_ys;
            r_y <= r_y - r_xs;
            r_z <= r_z + r_at;
          end else begin
            r_x <= r_x - r_ys;
            r_y <= r_y + r_xs;
            r_z <= r_z - r_at;
          end
          r_i <= r_i + IW'(1);
        end
        S_SCALE: r_m <= W2'(w_p >>> ZF);
        S_OUT: begin
          r_angle <= W'(r_z >>> guard_bits);
          r_mag   <= w_mag_sat;
          r_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready_out = r_ready;
  assign angle_out = r_angle;
  assign mag_out   = r_mag;
  assign err_out   = r_err;

endmodule

// File: tb/tb_cordic_vec_rtl.sv
// Self-checking bench for cordic_vec_rtl: directed corner cases, reset abort,
// start-held-high behaviour, and random vectors against a real-arithmetic
// atan2/sqrt reference.
module tb_cordic_vec_rtl;

  localparam int W       = 12;
  localparam int IMAX    = 10;
  localparam int GB      = 0;
  localparam int ONE     = 1 << (W - 2);
  localparam int MAG_MAX = (1 << (W - 1)) - 1;
  localparam int TOL     = 3;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic signed [W-1:0] x_in  = '0;
  logic signed [W-1:0] y_in  = '0;
  logic                ready_out;
  logic signed [W-1:0] angle_out;
  logic        [W-1:0] mag_out;
  logic                err_out;

  int vectors     = 0;
  int miscompares = 0;

  cordic_vec_rtl #(.W(W), .i_max(IMAX), .guard_bits(GB)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .ready_out (ready_out),
    .angle_out (angle_out),
    .mag_out   (mag_out),
    .err_out   (err_out)
  );

  // 100 MHz clock.
  always #5 clock = ~clock;

  // Reference model: ideal polar conversion in real arithmetic.
  function automatic bit forced_zero(input int x, input int y);
    return (x < 0) || (x == 0 && y == 0);
  endfunction

  function automatic int ideal_angle(input int x, input int y);
    if (forced_zero(x, y)) return 0;
    return int'($atan2(real'(y), real'(x)) * real'(ONE));
  endfunction

  function automatic int ideal_mag(input int x, input int y);
    if (forced_zero(x, y)) return 0;
    return int'($sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
  endfunction

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    vectors++;
    assert ((obs - exp) >= -TOL && (obs - exp) <= TOL) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d +-%0d", tag, obs, exp, TOL);
    end
  endtask

  // Issue one request; lat is the edge offset (0 = edge that samples start)
  // after which ready_out rose. start stays high afterwards when hold is set.
  task automatic request(input int x, input int y, input bit hold,
                         output int lat, output bit ok);
    bit seen_low;
    int n;
    @(posedge clock); #1;
    x_in  = W'(x);
    y_in  = W'(y);
    start = 1'b1;
    ok       = 1'b0;
    seen_low = 1'b0;
    n        = 0;
    while (!ok && n < 200) begin
      @(posedge clock); #1;
      if (!ready_out)    seen_low = 1'b1;
      else if (seen_low) ok = 1'b1;
      n++;
    end
    lat = n - 1;
    if (!hold) start = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input int x, input int y);
    int im;
    im = ideal_mag(x, y);
    check_eq({tag, " err"}, err_out, x < 0);
    if (forced_zero(x, y)) begin
      check_eq({tag, " angle"}, $signed(angle_out), 0);
      check_eq({tag, " mag"}, mag_out, 0);
    end else begin
      check_tol({tag, " angle"}, $signed(angle_out), ideal_angle(x, y));
      if (im > MAG_MAX + TOL) check_eq({tag, " mag"}, mag_out, MAG_MAX);
      else                    check_tol({tag, " mag"}, mag_out, (im > MAG_MAX) ? MAG_MAX : im);
    end
  endtask

  task automatic run_and_check(input string tag, input int x, input int y);
    int lat;
    bit ok;
    request(x, y, 1'b0, lat, ok);
    check_eq({tag, " ready"}, ok, 1);
    check_eq({tag, " latency"}, lat, forced_zero(x, y) ? 2 : 2 * IMAX + 3);
    check_outputs(tag, x, y);
  endtask

  // Directed steps followed by random vectors.
  initial begin
    int lat;
    int drops;
    int rx, ry;
    bit ok;

    // Reset state.
    #2 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset ready", ready_out, 0);
    check_eq("reset angle", $signed(angle_out), 0);
    check_eq("reset mag", mag_out, 0);
    check_eq("reset err", err_out, 0);
    reset = 1'b0;

    // Directed corners.
    run_and_check("x axis", ONE, 0);
    run_and_check("45 deg", ONE, ONE);
    run_and_check("-45 deg", ONE, -ONE);
    run_and_check("y axis", 0, ONE);
    run_and_check("origin", 0, 0);
    run_and_check("saturate", 2047, 2047);
    run_and_check("left half", -512, 100);
    run_and_check("after err", 700, -300);

    // Asynchronous reset in the middle of a computation.
    @(posedge clock); #1;
    x_in  = W'(ONE);
    y_in  = W'(512);
    start = 1'b1;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check_eq("abort ready", ready_out, 0);
    check_eq("abort angle", $signed(angle_out), 0);
    check_eq("abort mag", mag_out, 0);
    check_eq("abort err", err_out, 0);
    start = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    check_eq("no partial ready", ready_out, 0);
    check_eq("no partial mag", mag_out, 0);
    run_and_check("post abort", ONE, 512);

    // start held high after ready: exactly one computation, results held.
    request(ONE, -ONE, 1'b1, lat, ok);
    check_eq("hold ready", ok, 1);
    drops = 0;
    repeat (50) begin
      @(posedge clock); #1;
      if (!ready_out) drops++;
    end
    check_eq("hold no retrigger", drops, 0);
    check_outputs("hold", ONE, -ONE);
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check_eq("idle ready held", ready_out, 1);
    check_outputs("idle", ONE, -ONE);

    // Random vectors; every fifth lands in the left half-plane.
    for (int k = 0; k < 20; k++) begin
      if (k % 5 == 4) begin
        rx = -int'($urandom_range(2048, 1));
        ry = int'($urandom_range(4095, 0)) - 2048;
      end else begin
        do begin
          rx = int'($urandom_range(2047, 300));
          ry = int'($urandom_range(4094, 0)) - 2047;
        end while (rx * rx + ry * ry < ONE * ONE);
      end
      run_and_check($sformatf("rand%0d(%0d,%0d)", k, rx, ry), rx, ry);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
